// File: rtl/color_filter_sequencer.sv
// color_filter_sequencer: two-stage colour-blindness filter pipeline whose mode
// changes are deferred to the next vsync rising edge.
module color_filter_sequencer #(
    parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
    input  logic        clk_vid,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [23:0] rgb_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [1:0]  mode_req,
    input  logic        mode_req_valid,
    output logic [23:0] rgb_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic [1:0]  mode_active,
    output logic        mode_pending,
    output logic        mode_changed
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t            state;
    logic [1:0]        mode_req_r;
    logic              vs_prev;
    logic              vs_armed;
    logic              apply;
    logic [1:0]        mode_next;
    logic [5:0][15:0]  k;
    logic [5:0][15:0]  op;
    logic [5:0][15:0]  p;
    logic [2:0]        sync1;

    // Edge is only valid once a post-reset sample has been taken, so vs must be seen 0 then 1.
    assign apply        = ce_pix & vs_in & ~vs_prev & vs_armed & (state == PENDING) & ~mode_req_valid;
    assign mode_next    = apply ? mode_req_r : mode_active;
    assign mode_pending = (state == PENDING);

    // Coefficient order: R-out (a,b), G-out (a,b), B-out (a,b); mode 0 is unity passthrough.
    always_comb begin
        k = mode_next == 2'd1 ? {16'd160, 16'd96,  16'd179, 16'd77,  16'd77,  16'd179} :
            mode_next == 2'd2 ? {16'd145, 16'd111, 16'd143, 16'd113, 16'd61,  16'd194} :
            mode_next == 2'd3 ? {16'd243, 16'd13,  16'd111, 16'd145, 16'd121, 16'd134} :
                                {16'd256, 16'd0,   16'd0,   16'd256, 16'd0,   16'd256};
        op = {{8'd0, rgb_in[23:16]}, {8'd0, rgb_in[15:8]},
              {8'd0, mode_next == 2'd3 ? rgb_in[15:8] : rgb_in[23:16]},
              {8'd0, mode_next == 2'd3 ? rgb_in[7:0]  : rgb_in[15:8]},
              {8'd0, rgb_in[15:8]}, {8'd0, rgb_in[7:0]}};
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            state        <= IDLE;
            mode_req_r   <= DEFAULT_MODE;
            mode_active  <= DEFAULT_MODE;
            mode_changed <= 1'b0;
            vs_prev      <= 1'b0;
            vs_armed     <= 1'b0;
            p            <= '0;
            sync1        <= '0;
            rgb_out      <= '0;
            {hs_out, vs_out, de_out} <= 3'b000;
        end else begin
            if (ce_pix) begin
                vs_prev  <= vs_in;
                vs_armed <= 1'b1;
                for (int i = 0; i < 6; i++) p[i] <= k[i] * op[i];
                sync1    <= {hs_in, vs_in, de_in};
                rgb_out  <= {8'((p[5] + p[4]) >> 8), 8'((p[3] + p[2]) >> 8), 8'((p[1] + p[0]) >> 8)};
                {hs_out, vs_out, de_out} <= sync1;
            end
            mode_changed <= apply;
            if (mode_req_valid) begin
                mode_req_r <= mode_req;
                state      <= PENDING;
            end else if (apply) begin
                mode_active <= mode_req_r;
                state       <= IDLE;
            end
        end
    end
endmodule
